// File: rtl/clk_div_prog_if.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_prog_if
//  Purpose  : Control/status bundle for the programmable clock divider.
//             The master side drives enable and configuration writes; the
//             slave side (the divider) returns the divided clock, the
//             period-start tick and the configuration status flags.
//  Signals  : en          - 1: count, 0: freeze counter and outputs
//             cfg_we      - one-cycle pulse, capture cfg_div/cfg_high
//             cfg_div     - requested period in i_clk cycles (W bits)
//             cfg_high    - requested high time in i_clk cycles (W bits)
//             out_clk     - divided clock, registered
//             tick        - one-cycle pulse on the first cycle of a period
//             cfg_pending - shadow config waiting for the next period wrap
//             cfg_err     - one-cycle pulse, last written config was clamped
//  Revision : 1.0 - initial release
// ============================================================================
interface clk_div_prog_if #(
    parameter int W = 8
);
    logic         en;
    logic         cfg_we;
    logic [W-1:0] cfg_div;
    logic [W-1:0] cfg_high;
    logic         out_clk;
    logic         tick;
    logic         cfg_pending;
    logic         cfg_err;

    modport master (
        output en, cfg_we, cfg_div, cfg_high,
        input  out_clk, tick, cfg_pending, cfg_err
    );

    modport slave (
        input  en, cfg_we, cfg_div, cfg_high,
        output out_clk, tick, cfg_pending, cfg_err
    );
endinterface
`default_nettype wire

// File: rtl/clk_div_prog.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_prog
//  Purpose  : Runtime-programmable integer clock divider with programmable
//             high time. out_clk has a period of div_act i_clk cycles and is
//             high for the first high_act of them. New configuration lands in
//             a shadow register and is only promoted to the active set at a
//             period boundary, so the output never glitches.
//  Ports    : i_clk - clock (single domain)
//             rst   - synchronous active-high reset
//             bus   - clk_div_prog_if.slave (en, cfg_we, cfg_div, cfg_high in;
//                     out_clk, tick, cfg_pending, cfg_err out)
//  Params   : W        - counter/config width, max period 2^W-1
//             DEF_DIV  - period after reset, 1..2^W-1
//             DEF_HIGH - high time after reset, 0..DEF_DIV
//             W must match the W of the connected interface instance.
//  Revision : 1.0 - initial release
// ============================================================================
module clk_div_prog #(
    parameter int W        = 8,
    parameter int DEF_DIV  = 8,
    parameter int DEF_HIGH = 4
) (
    input wire             i_clk,
    input wire             rst,
    clk_div_prog_if.slave  bus
);

    localparam logic [W-1:0] c_def_div  = W'(DEF_DIV);
    localparam logic [W-1:0] c_def_high = W'(DEF_HIGH);
    // Counter parks on the last cycle of a period so that the first enabled
    // edge after reset is a wrap and starts a clean period.
    localparam logic [W-1:0] c_def_cnt  = W'(DEF_DIV - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [W-1:0] r_cnt;
    logic [W-1:0] r_div_act;
    logic [W-1:0] r_high_act;
    logic [W-1:0] r_div_sh;
    logic [W-1:0] r_high_sh;
    logic         r_out_clk;
    logic         r_tick;
    logic         r_pending;
    logic         r_err;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [W-1:0] w_div_cl;
    logic [W-1:0] w_high_cl;
    logic         w_clamp;
    logic [W:0]   w_cnt_inc;
    logic         w_wrap;

    // Clamp the requested config: a zero period becomes 1, and a high time
    // longer than the (clamped) period is cut to the period.
    always_comb begin
        w_div_cl  = bus.cfg_div;
        w_high_cl = bus.cfg_high;
        w_clamp   = 1'b0;
        if (bus.cfg_div == '0) begin
            w_div_cl = W'(1);
            w_clamp  = 1'b1;
        end
        if (bus.cfg_high > w_div_cl) begin
            w_high_cl = w_div_cl;
            w_clamp   = 1'b1;
        end
    end

    // One extra bit so cnt+1 cannot overflow when the period is 2^W-1.
    always_comb begin
        w_cnt_inc = {1'b0, r_cnt} + (W+1)'(1);
        w_wrap    = bus.en && (w_cnt_inc == {1'b0, r_div_act});
    end

    // ------------------------------------------------------------------------
    // Sequential
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (rst) begin
            r_cnt      <= c_def_cnt;
            r_div_act  <= c_def_div;
            r_high_act <= c_def_high;
            r_div_sh   <= c_def_div;
            r_high_sh  <= c_def_high;
            r_out_clk  <= 1'b0;
            r_tick     <= 1'b0;
            r_pending  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err <= bus.cfg_we && w_clamp;

            if (bus.cfg_we) begin
                r_div_sh  <= w_div_cl;
                r_high_sh <= w_high_cl;
            end

            // A write on the wrap edge itself is not consumed by that wrap,
            // so the write takes priority and the flag stays set.
            if (bus.cfg_we) begin
                r_pending <= 1'b1;
            end else if (w_wrap) begin
                r_pending <= 1'b0;
            end

            if (w_wrap) begin
                // Promote the shadow as it was before this edge.
                r_cnt      <= '0;
                r_div_act  <= r_div_sh;
                r_high_act <= r_high_sh;
                r_out_clk  <= (r_high_sh != '0);
                r_tick     <= 1'b1;
            end else if (bus.en) begin
                r_cnt     <= w_cnt_inc[W-1:0];
                r_out_clk <= (w_cnt_inc < {1'b0, r_high_act});
                r_tick    <= 1'b0;
            end else begin
                // Frozen: counter, clock level and active config hold.
                r_tick <= 1'b0;
            end
        end
    end

    assign bus.out_clk     = r_out_clk;
    assign bus.tick        = r_tick;
    assign bus.cfg_pending = r_pending;
    assign bus.cfg_err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_prog.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clk_div_prog
//  Purpose  : Self-checking bench for clk_div_prog. A behavioural model
//             tracks the position inside the current period and the active /
//             shadow configuration, and every scenario compares the DUT's
//             {out_clk, tick, cfg_pending, cfg_err} against it.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clk_div_prog;

    logic i_clk = 1'b0;
    logic rst   = 1'b1;

    always #5 i_clk = ~i_clk;

    clk_div_prog_if #(.W(8)) bus ();

    clk_div_prog #(
        .W       (8),
        .DEF_DIV (8),
        .DEF_HIGH(4)
    ) dut (
        .i_clk(i_clk),
        .rst  (rst),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- behavioural model ----------------
    // m_phase: index of the current cycle inside the period (0 = first).
    // m_fresh: the next enabled edge starts a new period (true after reset).
    int m_phase, m_div, m_high, m_sdiv, m_shigh;
    bit m_fresh, m_out, m_tick, m_pend, m_err;

    task automatic model_reset();
        m_fresh = 1'b1;
        m_phase = 0;
        m_div   = 8;  m_high  = 4;
        m_sdiv  = 8;  m_shigh = 4;
        m_out   = 1'b0; m_tick = 1'b0; m_pend = 1'b0; m_err = 1'b0;
    endtask

    function automatic logic [3:0] exp_vec();
        return {m_out, m_tick, m_pend, m_err};
    endfunction

    function automatic logic [3:0] obs_vec();
        return {bus.out_clk, bus.tick, bus.cfg_pending, bus.cfg_err};
    endfunction

    // Drive one cycle of inputs, advance one edge, update the model and
    // leave time 1 unit past the edge for sampling.
    task automatic step(input bit e, input bit we, input int d, input int h);
        int  dc, hc;
        bit  start;
        bus.en       = e;
        bus.cfg_we   = we;
        bus.cfg_div  = 8'(d);
        bus.cfg_high = 8'(h);
        @(posedge i_clk);
        dc    = (d == 0) ? 1 : d;
        hc    = (h > dc) ? dc : h;
        m_err = we && ((d == 0) || (h > dc));
        start = e && (m_fresh || (m_phase + 1 == m_div));
        m_tick = start;
        if (start) begin
            m_div   = m_sdiv;
            m_high  = m_shigh;
            m_phase = 0;
            m_fresh = 1'b0;
            m_pend  = 1'b0;
        end else if (e) begin
            m_phase = m_phase + 1;
        end
        if (e) m_out = (m_phase < m_high);
        if (we) begin
            m_sdiv  = dc;
            m_shigh = hc;
            m_pend  = 1'b1;
        end
        #1;
    endtask

    task automatic do_reset();
        bus.en = 1'b1; bus.cfg_we = 1'b0; bus.cfg_div = '0; bus.cfg_high = '0;
        rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        n_checks++;
        if (obs_vec() !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset: out/tick/pend/err got %b want 0000", obs_vec());
        end
    endtask

    task automatic test_defaults();
        int ticks = 0, highs = 0;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            step(1, 0, 0, 0);
            ticks += int'(bus.tick);
            highs += int'(bus.out_clk);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL defaults cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
            end
        end
        n_checks++;
        if (ticks !== 3 || highs !== 12) begin
            n_fail++;
            $display("FAIL defaults_shape: ticks %0d highs %0d want 3 12", ticks, highs);
        end
    endtask

    task automatic test_shadow();
        do_reset();
        repeat (3) step(1, 0, 0, 0);
        step(1, 1, 5, 2);
        n_checks++;
        if (bus.cfg_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL shadow_pending: got %b want 1", bus.cfg_pending);
        end
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 0, 0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL shadow cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_clamp();
        do_reset();
        step(1, 1, 3, 7);
        n_checks++;
        if (bus.cfg_err !== 1'b1) begin
            n_fail++;
            $display("FAIL clamp_err1: got %b want 1", bus.cfg_err);
        end
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0, 0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL clamp_hi cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
            end
        end
        step(1, 1, 0, 0);
        n_checks++;
        if (bus.cfg_err !== 1'b1) begin
            n_fail++;
            $display("FAIL clamp_err2: got %b want 1", bus.cfg_err);
        end
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0, 0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL clamp_zero cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_freeze();
        int  len = 1;
        bit  seen = 1'b0;
        do_reset();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0);
            len++;
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL freeze cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 30 && !seen; i++) begin
            step(1, 0, 0, 0);
            len++;
            seen = bus.tick;
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL freeze_run cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
            end
        end
        n_checks++;
        if (!seen || len !== 11) begin
            n_fail++;
            $display("FAIL freeze_period: got %0d (tick seen %0b) want 11", len, seen);
        end
    endtask

    task automatic test_wrap_write();
        do_reset();
        repeat (8) step(1, 0, 0, 0);
        step(1, 1, 6, 3);
        n_checks++;
        if (bus.tick !== 1'b1 || bus.cfg_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_write_edge: tick %b pend %b want 1 1", bus.tick, bus.cfg_pending);
        end
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 0, 0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL wrap_write cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_pending();
        do_reset();
        repeat (4) step(1, 0, 0, 0);
        step(1, 1, 5, 2);
        do_reset();
        n_checks++;
        if (obs_vec() !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_pending: got %b want 0000", obs_vec());
        end
        for (int i = 0; i < 12; i++) begin
            step(1, 0, 0, 0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_resume cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        bit e, we;
        int d, h;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            e  = ($urandom_range(0, 9) != 0);
            we = ($urandom_range(0, 15) == 0);
            d  = $urandom_range(0, 12);
            h  = $urandom_range(0, 14);
            if ($urandom_range(0, 19) == 0) d = $urandom_range(0, 255);
            step(e, we, d, h);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.en = 1'b0; bus.cfg_we = 1'b0; bus.cfg_div = '0; bus.cfg_high = '0;
        model_reset();
        test_reset();
        test_defaults();
        test_shadow();
        test_clamp();
        test_freeze();
        test_wrap_write();
        test_reset_pending();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
